// File: rtl/lcd_frame_fetch_ctrl.sv
// Burst-read scheduler that keeps the LCD pixel FIFO topped up from SDRAM, restarting per frame.
// Optional ping-pong frame buffers: define LCD_FETCH_PINGPONG_EN.
module lcd_frame_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 384000,
  parameter int unsigned FIFO_THRESH = 512,
  parameter int unsigned BASE0       = 0,
  parameter int unsigned BASE1       = 384000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_framesync,
  input  logic              lcd_request,
  input  logic              fifo_empty,
  input  logic [LVL_W-1:0]  fifo_level,
  output logic              fifo_clr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  input  logic              wr_frame_done,
  output logic              rd_bank,
  output logic              underrun
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFlush = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StReq   = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [19:0]       fetched_q, fetched_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic              abort_q, abort_d;
  logic              underrun_q, underrun_d;
  logic              sync_q, sync_prev_q;
  logic              frame_start;
  logic              below_thresh;
  logic [19:0]       remain;
  logic [ADDR_W-1:0] base;

  // Synchroniser flop plus edge history; both idle high so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 1'b1;
      sync_prev_q <= 1'b1;
    end else begin
      sync_q      <= lcd_framesync;
      sync_prev_q <= sync_q;
    end
  end

  assign frame_start  = sync_prev_q & ~sync_q;
  assign below_thresh = 32'(fifo_level) < FIFO_THRESH;
  assign remain       = 20'(FRAME_WORDS) - fetched_q;

`ifdef LCD_FETCH_PINGPONG_EN
  logic bank_q;
  logic wr_pend_q;
  logic fs_accept;

  assign fs_accept = frame_start && (state_q != StFlush);

  // A writer completion coinciding with a frame start is kept for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else if (fs_accept) begin
      bank_q    <= bank_q ^ wr_pend_q;
      wr_pend_q <= wr_frame_done;
    end else if (wr_frame_done) begin
      wr_pend_q <= 1'b1;
    end
  end

  assign rd_bank = bank_q;
  assign base    = bank_q ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
`else
  logic unused_wr_frame_done;

  assign unused_wr_frame_done = wr_frame_done;
  assign rd_bank              = 1'b0;
  assign base                 = ADDR_W'(BASE0);
`endif

  always_comb begin
    state_d   = state_q;
    fetched_d = fetched_q;
    addr_d    = addr_q;
    len_d     = len_q;
    abort_d   = abort_q;
    case (state_q)
      StIdle: begin
        if (frame_start) state_d = StFlush;
      end
      StFlush: begin
        fetched_d = '0;
        addr_d    = base;
        abort_d   = 1'b0;
        state_d   = StCheck;
      end
      StCheck: begin
        if (frame_start) begin
          state_d = StFlush;
        end else if (fetched_q == 20'(FRAME_WORDS)) begin
          state_d = StIdle;
        end else if (below_thresh) begin
          len_d   = (remain < 20'(BURST_LEN)) ? 9'(remain) : 9'(BURST_LEN);
          state_d = StReq;
        end
      end
      StReq: begin
        if (frame_start) abort_d = 1'b1;
        if (rd_ack) state_d = StWait;
      end
      StWait: begin
        if (frame_start) abort_d = 1'b1;
        if (rd_done) begin
          // An aborted burst still completes but its words belong to the old frame.
          if (abort_q || frame_start) begin
            abort_d = 1'b0;
            state_d = StFlush;
          end else begin
            addr_d    = addr_q + ADDR_W'(len_q);
            fetched_d = fetched_q + 20'(len_q);
            state_d   = StCheck;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    underrun_d = underrun_q | (lcd_request & fifo_empty);
    if (state_q == StFlush) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetched_q  <= '0;
      addr_q     <= ADDR_W'(BASE0);
      len_q      <= '0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetched_q  <= fetched_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo_clr = (state_q == StFlush);
  assign rd_req   = (state_q == StReq);
  assign rd_addr  = addr_q;
  assign rd_len   = len_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_lcd_frame_fetch_ctrl.sv
// Scoreboard bench for lcd_frame_fetch_ctrl: expected bursts are queued per frame start
// and checked as each read command appears.
module tb_lcd_frame_fetch_ctrl;

  localparam int unsigned FW    = 1000;
  localparam int unsigned BL    = 256;
  localparam int unsigned THR   = 512;
  localparam int unsigned B1    = 4096;
`ifdef LCD_FETCH_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef struct {
    logic [23:0] addr;
    logic [8:0]  len;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_framesync;
  logic        lcd_request;
  logic        fifo_empty;
  logic [9:0]  fifo_level;
  logic        fifo_clr;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [8:0]  rd_len;
  logic        rd_ack;
  logic        rd_done;
  logic        wr_frame_done;
  logic        rd_bank;
  logic        underrun;

  int     lvl;
  int     n_vec = 0;
  int     n_err = 0;
  burst_t sb[$];

  assign fifo_level = 10'(lvl);
  assign fifo_empty = (lvl == 0);

  lcd_frame_fetch_ctrl #(
    .FRAME_WORDS(FW),
    .BURST_LEN  (BL),
    .FIFO_THRESH(THR),
    .BASE1      (B1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_framesync(lcd_framesync),
    .lcd_request  (lcd_request),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .fifo_clr     (fifo_clr),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_done      (rd_done),
    .wr_frame_done(wr_frame_done),
    .rd_bank      (rd_bank),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [23:0] base);
    for (int off = 0; off < int'(FW); off += int'(BL)) begin
      burst_t b;
      b.addr = base + 24'(off);
      b.len  = 9'((int'(FW) - off) < int'(BL) ? int'(FW) - off : int'(BL));
      sb.push_back(b);
    end
  endtask

  // Frame start from IDLE/CHECK; new_lvl is presented while the flush is in progress.
  task automatic frame_start_seq(input int new_lvl);
    lcd_framesync = 1'b0;
    step();
    check("fifo_clr_early", 32'(fifo_clr), 32'(0));
    step();
    check("fifo_clr_pulse", 32'(fifo_clr), 32'(1));
    lvl           = new_lvl;
    lcd_framesync = 1'b1;
    step();
    check("fifo_clr_width", 32'(fifo_clr), 32'(0));
    check("underrun_cleared", 32'(underrun), 32'(0));
    step();
    check("first_rd_req", 32'(rd_req), 32'(new_lvl < int'(THR)));
  endtask

  task automatic take_cmd(input int ack_delay);
    burst_t e;
    int     t = 0;
    while (!rd_req && t < 40) begin
      step();
      t++;
    end
    check("rd_req_seen", 32'(rd_req), 32'(1));
    if (!rd_req) return;
    check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("rd_addr", 32'(rd_addr), 32'(e.addr));
    check("rd_len", 32'(rd_len), 32'(e.len));
    for (int i = 0; i < ack_delay; i++) begin
      step();
      check("rd_req_hold", 32'(rd_req), 32'(1));
      check("rd_addr_hold", 32'(rd_addr), 32'(e.addr));
      check("rd_len_hold", 32'(rd_len), 32'(e.len));
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("rd_req_drop", 32'(rd_req), 32'(0));
  endtask

  task automatic finish_burst(input int d);
    repeat (d) step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t e;
    int     cnt;
    rst_n         = 1'b0;
    lcd_framesync = 1'b1;
    lcd_request   = 1'b0;
    rd_ack        = 1'b0;
    rd_done       = 1'b0;
    wr_frame_done = 1'b0;
    lvl           = 0;
    repeat (2) step();
    check("rst_fifo_clr", 32'(fifo_clr), 32'(0));
    check("rst_rd_req", 32'(rd_req), 32'(0));
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_rd_len", 32'(rd_len), 32'(0));
    check("rst_rd_bank", 32'(rd_bank), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    rst_n = 1'b1;
    repeat (2) step();

    // Full frame, including a 5-cycle ack delay on burst 2.
    push_frame(24'd0);
    frame_start_seq(0);
    take_cmd(0); finish_burst(3);
    take_cmd(5); finish_burst(2);
    take_cmd(1); finish_burst(0);
    take_cmd(0); finish_burst(4);
    cnt = 0;
    repeat (20) begin
      step();
      if (rd_req) cnt++;
    end
    check("no_req_after_frame", 32'(cnt), 32'(0));
    check("sb_drained", 32'(sb.size()), 32'(0));

    // Threshold gating.
    push_frame(24'd0);
    frame_start_seq(600);
    cnt = 0;
    repeat (10) begin
      step();
      if (rd_req) cnt++;
    end
    check("no_req_above_thresh", 32'(cnt), 32'(0));
    lvl = 400;
    step();
    check("req_below_thresh", 32'(rd_req), 32'(1));
    lvl = 0;
    take_cmd(0); finish_burst(2);
    take_cmd(2);

    // Frame start while burst 2 is in flight.
    lcd_framesync = 1'b0;
    cnt = 0;
    repeat (6) begin
      step();
      lcd_framesync = 1'b1;
      if (rd_req || fifo_clr) cnt++;
    end
    check("quiet_during_abort", 32'(cnt), 32'(0));
    sb.delete();
    push_frame(24'd0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("abort_flush", 32'(fifo_clr), 32'(1));
    step();
    check("abort_flush_width", 32'(fifo_clr), 32'(0));
    step();
    check("abort_refetch_req", 32'(rd_req), 32'(1));
    for (int i = 0; i < 4; i++) begin
      take_cmd(0);
      finish_burst(1);
    end
    check("sb_drained_abort", 32'(sb.size()), 32'(0));

    // Sticky underrun, cleared by the next flush.
    lvl         = 0;
    lcd_request = 1'b1;
    step();
    lcd_request = 1'b0;
    check("underrun_set", 32'(underrun), 32'(1));
    repeat (5) step();
    check("underrun_sticky", 32'(underrun), 32'(1));
    frame_start_seq(600);

    // Bank swap (ping-pong build) or unaffected bank (default build).
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    step();
    push_frame(PP ? 24'(B1) : 24'd0);
    frame_start_seq(0);
    check("bank_after_swap", 32'(rd_bank), 32'(PP));
    for (int i = 0; i < 4; i++) begin
      take_cmd(0);
      finish_burst(1);
    end
    push_frame(PP ? 24'(B1) : 24'd0);
    frame_start_seq(0);
    check("bank_kept", 32'(rd_bank), 32'(PP));
    e = sb.pop_front();
    check("bank_kept_addr", 32'(rd_addr), 32'(e.addr));

    // Asynchronous reset with a command outstanding.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd_req", 32'(rd_req), 32'(0));
    check("async_rst_rd_addr", 32'(rd_addr), 32'(0));
    check("async_rst_rd_len", 32'(rd_len), 32'(0));
    check("async_rst_rd_bank", 32'(rd_bank), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
